// File: rtl/mdom_wvb_hdr_fifo_if.sv
// Header FIFO read port: head word, length and valid/ready handshake.
// The FIFO drives the master side; the readout arbiter takes the slave side.
interface mdom_wvb_hdr_fifo_if #(
  parameter int P_BUN_W = 80,
  parameter int P_LEN_W = 12
);
  logic [P_BUN_W-1:0] hdr_bundle;
  logic [P_LEN_W-1:0] hdr_len;
  logic               hdr_valid;
  logic               hdr_rdy;

  modport master (
    output hdr_bundle,
    output hdr_len,
    output hdr_valid,
    input  hdr_rdy
  );

  modport slave (
    input  hdr_bundle,
    input  hdr_len,
    input  hdr_valid,
    output hdr_rdy
  );
endinterface

// File: rtl/mdom_wvb_hdr_fifo.sv
// Waveform-buffer header FIFO: packs header fields on capture, stores them
// in a first-word-fall-through FIFO with registered head and drop counter.
module mdom_wvb_hdr_fifo #(
  parameter int P_LTC_W      = 49,
  parameter int P_ADR_W      = 11,
  parameter int P_CONF_W     = 5,
  parameter int P_DEPTH_LOG2 = 4,
  parameter int P_OVF_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    hdr_wr,
  input  logic [P_LTC_W-1:0]      evt_ltc,
  input  logic [P_ADR_W-1:0]      start_addr,
  input  logic [P_ADR_W-1:0]      stop_addr,
  input  logic [1:0]              trig_src,
  input  logic                    cnst_run,
  input  logic [P_CONF_W-1:0]     pre_conf,
  input  logic                    sync_rdy,
  mdom_wvb_hdr_fifo_if.master     rd,
  output logic [P_DEPTH_LOG2:0]   fill_cnt,
  output logic                    full,
  output logic                    ovf_sticky,
  output logic [P_OVF_W-1:0]      ovf_cnt,
  input  logic                    ovf_clr
);

  localparam int W = P_LTC_W + 2*P_ADR_W + P_CONF_W + 4;
  localparam int L = P_ADR_W + 1;
  localparam int E = W + L;
  localparam int D = 2**P_DEPTH_LOG2;
  localparam int C = P_DEPTH_LOG2 + 1;

  logic [E-1:0]              mem [D];
  logic [P_DEPTH_LOG2-1:0]   wr_ptr;
  logic [P_DEPTH_LOG2-1:0]   rd_ptr;
  logic [P_DEPTH_LOG2-1:0]   rd_nxt;
  logic [C-1:0]              cnt_left;
  logic [C-1:0]              cnt_nxt;
  logic [P_ADR_W-1:0]        diff;
  logic [E-1:0]              wr_word;
  logic [E-1:0]              head_nxt;
  logic                      pop;
  logic                      wr_en;
  logic                      drop;

  // Length is stored with the entry; the modulo falls out of the
  // address-width subtraction.
  assign diff    = stop_addr - start_addr;
  assign wr_word = {L'(diff) + L'(1),
                    sync_rdy, pre_conf, cnst_run, trig_src,
                    stop_addr, start_addr, evt_ltc};

  assign full  = (fill_cnt == C'(D));
  assign pop   = rd.hdr_valid & rd.hdr_rdy;
  assign wr_en = hdr_wr & (~full | pop);
  assign drop  = hdr_wr & full & ~pop;

  // Bypass the array when the incoming word becomes the new head.
  always_comb begin
    rd_nxt   = rd_ptr + P_DEPTH_LOG2'(pop);
    cnt_left = fill_cnt - C'(pop);
    cnt_nxt  = cnt_left + C'(wr_en);
    head_nxt = (cnt_left == '0) ? wr_word : mem[rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fill_cnt      <= '0;
      rd.hdr_valid  <= 1'b0;
      rd.hdr_bundle <= '0;
      rd.hdr_len    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr       <= rd_nxt;
      fill_cnt     <= cnt_nxt;
      rd.hdr_valid <= (cnt_nxt != '0);
      if (cnt_nxt != '0) begin
        rd.hdr_bundle <= head_nxt[W-1:0];
        rd.hdr_len    <= head_nxt[E-1:W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      ovf_cnt    <= '0;
    end else if (ovf_clr) begin
      ovf_sticky <= drop;
      ovf_cnt    <= P_OVF_W'(drop);
    end else if (drop) begin
      ovf_sticky <= 1'b1;
      if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mdom_wvb_hdr_fifo.sv
// Bench for the header FIFO: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_mdom_wvb_hdr_fifo;

  localparam int LTC = 49;
  localparam int ADR = 11;
  localparam int BW  = 80;
  localparam int LW  = 12;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           hdr_wr;
  logic [LTC-1:0] evt_ltc;
  logic [ADR-1:0] start_addr;
  logic [ADR-1:0] stop_addr;
  logic [1:0]     trig_src;
  logic           cnst_run;
  logic [4:0]     pre_conf;
  logic           sync_rdy;
  logic [4:0]     fill_cnt;
  logic           full;
  logic           ovf_sticky;
  logic [3:0]     ovf_cnt;
  logic           ovf_clr;

  mdom_wvb_hdr_fifo_if #(.P_BUN_W(BW), .P_LEN_W(LW)) rd ();

  mdom_wvb_hdr_fifo #(
    .P_LTC_W(49), .P_ADR_W(11), .P_CONF_W(5),
    .P_DEPTH_LOG2(4), .P_OVF_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hdr_wr(hdr_wr),
    .evt_ltc(evt_ltc), .start_addr(start_addr),
    .stop_addr(stop_addr), .trig_src(trig_src),
    .cnst_run(cnst_run), .pre_conf(pre_conf),
    .sync_rdy(sync_rdy), .rd(rd),
    .fill_cnt(fill_cnt), .full(full),
    .ovf_sticky(ovf_sticky), .ovf_cnt(ovf_cnt),
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [LW+BW-1:0] q[$];
  int  m_ovf = 0;
  bit  m_sticky = 0;

  function automatic logic [LW+BW-1:0] model_word();
    int len;
    len = ((int'(stop_addr) - int'(start_addr) + 2048) % 2048) + 1;
    return {LW'(len), sync_rdy, pre_conf, cnst_run, trig_src,
            stop_addr, start_addr, evt_ltc};
  endfunction

  task automatic rand_fields();
    evt_ltc    = LTC'({$urandom(), $urandom()});
    start_addr = ADR'($urandom());
    stop_addr  = ADR'($urandom());
    trig_src   = 2'($urandom());
    cnst_run   = 1'($urandom());
    pre_conf   = 5'($urandom());
    sync_rdy   = 1'($urandom());
  endtask

  // One clock: update the model from current inputs, then land on negedge.
  task automatic cyc();
    bit pop, drop;
    logic [LW+BW-1:0] w;
    pop  = (q.size() != 0) && rd.hdr_rdy;
    drop = hdr_wr && (q.size() == 16) && !pop;
    w    = model_word();
    if (pop) void'(q.pop_front());
    if (hdr_wr && !drop) q.push_back(w);
    if (ovf_clr) begin
      m_sticky = drop;
      m_ovf    = drop ? 1 : 0;
    end else if (drop) begin
      m_sticky = 1;
      if (m_ovf < 15) m_ovf++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_chk++;
    if (rd.hdr_valid !== 1'b0 || rd.hdr_bundle !== '0 ||
        rd.hdr_len !== '0 || fill_cnt !== '0 || full !== 1'b0 ||
        ovf_sticky !== 1'b0 || ovf_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset: valid=%b bundle=%h len=%h fill=%0d full=%b stk=%b ovf=%0d required all 0",
               rd.hdr_valid, rd.hdr_bundle, rd.hdr_len, fill_cnt,
               full, ovf_sticky, ovf_cnt);
    end
  endtask

  task automatic test_single();
    evt_ltc = 49'h1_2345_6789_ABCD;
    start_addr = 11'h010; stop_addr = 11'h01F;
    trig_src = 2'd2; cnst_run = 1'b1; pre_conf = 5'h15; sync_rdy = 1'b1;
    hdr_wr = 1'b1; rd.hdr_rdy = 1'b0;
    cyc();
    hdr_wr = 1'b0;
    n_chk++;
    if (rd.hdr_valid !== 1'b1 || fill_cnt !== 5'd1) begin
      n_fail++;
      $display("FAIL single_valid: valid=%b fill=%0d required 1 1",
               rd.hdr_valid, fill_cnt);
    end
    n_chk++;
    if (rd.hdr_bundle[48:0] !== 49'h1_2345_6789_ABCD ||
        rd.hdr_bundle[59:49] !== 11'h010 ||
        rd.hdr_bundle[70:60] !== 11'h01F ||
        rd.hdr_bundle[72:71] !== 2'd2 || rd.hdr_bundle[73] !== 1'b1 ||
        rd.hdr_bundle[78:74] !== 5'h15 || rd.hdr_bundle[79] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_fields: bundle=%h required %h", rd.hdr_bundle,
               {1'b1, 5'h15, 1'b1, 2'd2, 11'h01F, 11'h010, 49'h1_2345_6789_ABCD});
    end
    n_chk++;
    if (rd.hdr_len !== 12'd16) begin
      n_fail++;
      $display("FAIL single_len: len=%0d required 16", rd.hdr_len);
    end
    cyc();
    n_chk++;
    if (rd.hdr_valid !== 1'b1 || rd.hdr_bundle[48:0] !== 49'h1_2345_6789_ABCD) begin
      n_fail++;
      $display("FAIL single_hold: valid=%b ltc=%h required 1 123456789abcd",
               rd.hdr_valid, rd.hdr_bundle[48:0]);
    end
    rd.hdr_rdy = 1'b1;
    cyc();
    n_chk++;
    if (rd.hdr_valid !== 1'b0 || fill_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL single_pop: valid=%b fill=%0d required 0 0",
               rd.hdr_valid, fill_cnt);
    end
    rd.hdr_rdy = 1'b0;
  endtask

  task automatic test_wrap_len();
    rand_fields();
    start_addr = 11'h7F0; stop_addr = 11'h00F; hdr_wr = 1'b1;
    cyc();
    rand_fields();
    start_addr = 11'h100; stop_addr = 11'h0FF;
    cyc();
    hdr_wr = 1'b0;
    n_chk++;
    if (rd.hdr_len !== 12'd32) begin
      n_fail++;
      $display("FAIL wrap_len32: len=%0d required 32", rd.hdr_len);
    end
    rd.hdr_rdy = 1'b1;
    cyc();
    n_chk++;
    if (rd.hdr_len !== 12'd2048 || rd.hdr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_len2048: len=%0d valid=%b required 2048 1",
               rd.hdr_len, rd.hdr_valid);
    end
    cyc();
    rd.hdr_rdy = 1'b0;
  endtask

  task automatic test_fill_ovf();
    logic [LTC-1:0] ltcs[$];
    hdr_wr = 1'b1; rd.hdr_rdy = 1'b0;
    for (int i = 0; i < 19; i++) begin
      rand_fields();
      ltcs.push_back(evt_ltc);
      cyc();
    end
    hdr_wr = 1'b0;
    n_chk++;
    if (full !== 1'b1 || fill_cnt !== 5'd16 ||
        ovf_sticky !== 1'b1 || ovf_cnt !== 4'd3) begin
      n_fail++;
      $display("FAIL fill_ovf: full=%b fill=%0d stk=%b ovf=%0d required 1 16 1 3",
               full, fill_cnt, ovf_sticky, ovf_cnt);
    end
    rd.hdr_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_chk++;
      if (rd.hdr_valid !== 1'b1 || rd.hdr_bundle[48:0] !== ltcs[i]) begin
        n_fail++;
        $display("FAIL drain_%0d: valid=%b ltc=%h required 1 %h",
                 i, rd.hdr_valid, rd.hdr_bundle[48:0], ltcs[i]);
      end
      cyc();
    end
    n_chk++;
    if (rd.hdr_valid !== 1'b0 || fill_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL drain_empty: valid=%b fill=%0d required 0 0",
               rd.hdr_valid, fill_cnt);
    end
    rd.hdr_rdy = 1'b0;
  endtask

  task automatic test_full_rw();
    logic [LTC-1:0] last;
    hdr_wr = 1'b1; rd.hdr_rdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rand_fields();
      cyc();
    end
    rand_fields();
    last = evt_ltc;
    rd.hdr_rdy = 1'b1;
    cyc();
    hdr_wr = 1'b0; rd.hdr_rdy = 1'b0;
    n_chk++;
    if (fill_cnt !== 5'd16 || full !== 1'b1 || ovf_cnt !== 4'd3) begin
      n_fail++;
      $display("FAIL full_rw: fill=%0d full=%b ovf=%0d required 16 1 3",
               fill_cnt, full, ovf_cnt);
    end
    rd.hdr_rdy = 1'b1;
    for (int i = 0; i < 15; i++) cyc();
    n_chk++;
    if (rd.hdr_valid !== 1'b1 || fill_cnt !== 5'd1 ||
        rd.hdr_bundle[48:0] !== last) begin
      n_fail++;
      $display("FAIL full_rw_last: valid=%b fill=%0d ltc=%h required 1 1 %h",
               rd.hdr_valid, fill_cnt, rd.hdr_bundle[48:0], last);
    end
    cyc();
    rd.hdr_rdy = 1'b0;
  endtask

  task automatic test_sat_clr();
    hdr_wr = 1'b1; rd.hdr_rdy = 1'b0;
    for (int i = 0; i < 36; i++) begin
      rand_fields();
      cyc();
    end
    n_chk++;
    if (ovf_cnt !== 4'd15 || ovf_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sat: ovf=%0d stk=%b required 15 1", ovf_cnt, ovf_sticky);
    end
    hdr_wr = 1'b0; ovf_clr = 1'b1;
    cyc();
    n_chk++;
    if (ovf_cnt !== 4'd0 || ovf_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clr: ovf=%0d stk=%b required 0 0", ovf_cnt, ovf_sticky);
    end
    hdr_wr = 1'b1;
    cyc();
    hdr_wr = 1'b0; ovf_clr = 1'b0;
    n_chk++;
    if (ovf_cnt !== 4'd1 || ovf_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_clr_drop: ovf=%0d stk=%b required 1 1", ovf_cnt, ovf_sticky);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rand_fields();
      hdr_wr     = ($urandom_range(0, 99) < 55);
      rd.hdr_rdy = ($urandom_range(0, 99) < 45);
      ovf_clr    = ($urandom_range(0, 99) < 4);
      cyc();
      n_chk++;
      if (rd.hdr_valid !== (q.size() != 0) || fill_cnt !== 5'(q.size()) ||
          full !== (q.size() == 16) || ovf_sticky !== m_sticky ||
          ovf_cnt !== 4'(m_ovf) ||
          (q.size() != 0 && {rd.hdr_len, rd.hdr_bundle} !== q[0])) begin
        n_fail++;
        $display("FAIL random_%0d: valid=%b fill=%0d full=%b stk=%b ovf=%0d head=%h required fill=%0d stk=%b ovf=%0d head=%h",
                 c, rd.hdr_valid, fill_cnt, full, ovf_sticky, ovf_cnt,
                 {rd.hdr_len, rd.hdr_bundle}, q.size(), m_sticky, m_ovf,
                 (q.size() != 0) ? q[0] : '0);
      end
    end
    hdr_wr = 1'b0; rd.hdr_rdy = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [LW+BW-1:0] w;
    hdr_wr = 1'b1; rd.hdr_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_fields();
      cyc();
    end
    hdr_wr = 1'b0;
    #2 rst_n = 1'b0;
    q.delete(); m_ovf = 0; m_sticky = 0;
    #1;
    n_chk++;
    if (rd.hdr_valid !== 1'b0 || fill_cnt !== 5'd0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b fill=%0d full=%b required 0 0 0",
               rd.hdr_valid, fill_cnt, full);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (rd.hdr_valid !== 1'b0 || fill_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL post_reset: valid=%b fill=%0d required 0 0",
               rd.hdr_valid, fill_cnt);
    end
    rand_fields();
    w = model_word();
    hdr_wr = 1'b1;
    cyc();
    hdr_wr = 1'b0;
    n_chk++;
    if (rd.hdr_valid !== 1'b1 || fill_cnt !== 5'd1 ||
        {rd.hdr_len, rd.hdr_bundle} !== w) begin
      n_fail++;
      $display("FAIL post_reset_write: valid=%b fill=%0d head=%h required 1 1 %h",
               rd.hdr_valid, fill_cnt, {rd.hdr_len, rd.hdr_bundle}, w);
    end
  endtask

  initial begin
    rst_n = 1'b0; hdr_wr = 1'b0; ovf_clr = 1'b0; rd.hdr_rdy = 1'b0;
    evt_ltc = '0; start_addr = '0; stop_addr = '0; trig_src = '0;
    cnst_run = 1'b0; pre_conf = '0; sync_rdy = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_single();
    test_wrap_len();
    test_fill_ovf();
    test_full_rw();
    test_sat_clr();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mdom_wvb_hdr_fifo.md
Name: mdom_wvb_hdr_fifo

Overview:
Parametrised successor to the waveform-buffer header fan-in. It packs per-waveform header fields into one bundle word on a capture strobe and stores the words in a first-word-fall-through FIFO. Each stored word is presented on a valid/ready read port together with a derived waveform length. It sits between the waveform-buffer write controller, which captures headers, and the readout arbiter, which consumes them. Overflow drops are counted, not silently lost.

Parameters:
P_LTC_W, 49, event local-time-counter width
P_ADR_W, 11, waveform buffer address width
P_CONF_W, 5, pre-trigger configuration width
P_DEPTH_LOG2, 4, FIFO depth = 2**P_DEPTH_LOG2 entries
P_OVF_W, 16, overflow drop counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
hdr_wr  in  1  capture strobe; fields sampled this cycle
evt_ltc  in  P_LTC_W  event LTC
start_addr  in  P_ADR_W  first sample address
stop_addr  in  P_ADR_W  last sample address
trig_src  in  2  trigger source code
cnst_run  in  1  constant-run flag
pre_conf  in  P_CONF_W  pre-trigger configuration
sync_rdy  in  1  LTC sync-ready flag
hdr_bundle  out  W  head entry; W = P_LTC_W+2*P_ADR_W+P_CONF_W+4 (80 at defaults)
hdr_len  out  P_ADR_W+1  head waveform length in samples
hdr_valid  out  1  head entry valid
hdr_rdy  in  1  consumer accepts head when hdr_valid high
fill_cnt  out  P_DEPTH_LOG2+1  entries stored
full  out  1  fill_cnt == depth
ovf_sticky  out  1  at least one drop since last clear
ovf_cnt  out  P_OVF_W  drops since last clear, saturating
ovf_clr  in  1  synchronous clear of ovf_sticky and ovf_cnt

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values: all outputs 0. This includes hdr_bundle, hdr_len, hdr_valid, fill_cnt, full, ovf_sticky and ovf_cnt. FIFO pointers are 0.
- Bundle packing, LSB first: evt_ltc, start_addr, stop_addr, trig_src, cnst_run, pre_conf, sync_rdy. At defaults the layout is bit-identical to the existing 80-bit header bundle: [48:0], [59:49], [70:60], [72:71], [73], [78:74], [79].
- Write: hdr_wr high and the FIFO is not full, or it is full and a read occurs in the same cycle. The packed word is stored at the write pointer and the pointer increments modulo depth.
- Drop: hdr_wr high, full high and no read that cycle. The word is discarded, ovf_sticky is set and ovf_cnt increments. ovf_cnt saturates at all-ones and never wraps.
- ovf_clr: clears ovf_sticky and ovf_cnt next cycle. If ovf_clr and a drop occur in the same cycle, the result is ovf_sticky=1 and ovf_cnt=1.
- Read: hdr_valid & hdr_rdy pops the head. hdr_rdy while hdr_valid is low is ignored.
- First-word fall-through:
  - A write into an empty FIFO gives hdr_valid=1 and a valid hdr_bundle/hdr_len on the next cycle. Latency is 1 clock.
  - hdr_bundle and hdr_len are registered and stable while hdr_valid=1 and hdr_rdy=0.
- Simultaneous write and read: fill_cnt is unchanged. When fill_cnt==1, the new word becomes head on the next cycle with no bubble.
- fill_cnt and full update one cycle after the write or pop event.
- Length arithmetic: hdr_len = ((stop_addr - start_addr) mod 2**P_ADR_W) + 1, computed at capture time and stored alongside the entry.
  - Wrap-around is handled by the modulo.
  - stop_addr == start_addr gives 1.
  - stop_addr == start_addr-1 gives 2**P_ADR_W.
- Pointers wrap modulo depth. Full and empty are distinguished by fill_cnt, not by pointer equality.
- Mid-operation reset: rst_n low discards all entries immediately. Outputs go to reset values asynchronously, and no partial word is presented after release.

Test Plan:
- Reset, single write, pop: write evt_ltc=0x1_2345_6789_ABCD, start=0x010, stop=0x01F, trig_src=2, cnst_run=1, pre_conf=0x15, sync_rdy=1 with hdr_rdy=0. Required: next cycle hdr_valid=1, bundle fields at defined offsets, hdr_len=16, fill_cnt=1. Raise hdr_rdy: hdr_valid=0 and fill_cnt=0 next cycle.
- Wrap length: start=0x7F0, stop=0x00F -> hdr_len=32. start=0x100, stop=0x0FF -> hdr_len=2048.
- Fill and overflow: write 16 entries with hdr_rdy=0, then 3 more. Required: full=1, fill_cnt=16, ovf_sticky=1, ovf_cnt=3. Drain: 16 words in write order, first 16 LTCs only.
- Full with read and write in the same cycle: write accepted, ovf_cnt unchanged, fill_cnt stays 16. The last word read out is the new one.
- Saturation and clear: with P_OVF_W=4, force 20 drops -> ovf_cnt=15. ovf_clr alone -> ovf_sticky=0, ovf_cnt=0. ovf_clr together with a drop -> ovf_sticky=1, ovf_cnt=1.
- Reset mid-stream: 5 entries stored, assert rst_n low for one cycle asynchronously. Required: hdr_valid=0, fill_cnt=0, full=0 without waiting for a clock edge. After release, the first new write reads back correctly.
